console_tx_fifo: RTL

//  Byte buffer between the CPU data bus and the console sink. CPU stores to DATA
//  are queued; a master FSM drains one byte at a time to the console's Wishbone

---
 rtl/console_pkg.sv | 37 +++
 rtl/console_tx_fifo_sync_fifo.sv | 57 +++++
 rtl/console_tx_fifo.sv | 125 ++++++++++++
 3 files changed

// File: rtl/console_pkg.sv
// Shared constants, status layout and drain FSM encoding
// for the console transmit buffer.
package console_pkg;

   localparam int CON_DEPTH = 16;
   localparam int CON_AW    = 4;

   localparam logic CON_ADDR_DATA   = 1'b0;
   localparam logic CON_ADDR_STATUS = 1'b1;

   localparam int ST_EMPTY     = 0;
   localparam int ST_FULL      = 1;
   localparam int ST_BUSY      = 2;
   localparam int ST_COUNT_LSB = 8;

   typedef enum logic [1:0] {
      DRN_IDLE = 2'd0,
      DRN_REQ  = 2'd1,
      DRN_WAIT = 2'd2
   } drain_state_t;

   function automatic logic [31:0] status_word(
      input logic       empty,
      input logic       full,
      input logic       busy,
      input logic [7:0] count
   );
      logic [31:0] w;
      w                        = '0;
      w[ST_EMPTY]              = empty;
      w[ST_FULL]               = full;
      w[ST_BUSY]               = busy;
      w[ST_COUNT_LSB +: 8]     = count;
      return w;
   endfunction

endpackage

// File: rtl/console_tx_fifo_sync_fifo.sv
// Power-of-two synchronous FIFO with combinational head
// and a registered occupancy count.
module sync_fifo
   import console_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = CON_DEPTH,
   parameter int AW    = CON_AW
) (
   input  logic             i_clk,
   input  logic             i_reset_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_head,
   output logic             o_full,
   output logic             o_empty,
   output logic [AW:0]      o_count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign o_full  = (count == (AW+1)'(DEPTH));
   assign o_empty = (count == '0);
   assign o_count = count;
   assign o_head  = mem[rd_ptr];

   assign do_push = i_push && !o_full;
   assign do_pop  = i_pop && !o_empty;

   // Pointers are exactly AW bits, so wrap is free
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         unique case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (do_push) mem[wr_ptr] <= i_data;
   end

endmodule

// File: rtl/console_tx_fifo.sv
// CPU-facing MMIO byte queue with a single-outstanding
// Wishbone master draining bytes to the console.
module console_tx_fifo
   import console_pkg::*;
#(
   parameter int DEPTH = CON_DEPTH,
   parameter int AW    = CON_AW
) (
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic        i_wb_stb,
   input  logic        i_wb_we,
   input  logic        i_wb_addr,
   input  logic [31:0] i_wb_data,
   output logic [31:0] o_wb_data,
   output logic        o_wb_ack,
   output logic        o_wb_stall,
   output logic        o_con_stb,
   output logic [31:0] o_con_data,
   input  logic        i_con_ack,
   input  logic        i_con_stall
);

   logic         full;
   logic         empty;
   logic [AW:0]  count;
   logic [7:0]   head;
   logic         is_data;
   logic         accept;
   logic         push;
   logic         pop;
   logic [31:0]  status;

   drain_state_t state;
   drain_state_t state_n;
   logic         con_stb_n;
   logic [31:0]  con_data_n;

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_fifo (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_push    (push),
      .i_data    (i_wb_data[7:0]),
      .i_pop     (pop),
      .o_head    (head),
      .o_full    (full),
      .o_empty   (empty),
      .o_count   (count)
   );

   assign is_data    = (i_wb_addr == CON_ADDR_DATA);
   assign o_wb_stall = i_wb_we && is_data && full;
   assign accept     = i_wb_stb && !o_wb_stall;
   assign push       = accept && i_wb_we && is_data;
   assign status     = status_word(empty, full,
                                   state != DRN_IDLE,
                                   8'(count));

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         o_wb_ack  <= 1'b0;
         o_wb_data <= '0;
      end else begin
         o_wb_ack <= accept;
         if (accept && !i_wb_we && !is_data)
            o_wb_data <= status;
         else
            o_wb_data <= '0;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state      <= DRN_IDLE;
         o_con_stb  <= 1'b0;
         o_con_data <= '0;
      end else begin
         state      <= state_n;
         o_con_stb  <= con_stb_n;
         o_con_data <= con_data_n;
      end
   end

   // Ack in the accepting REQ cycle skips WAIT entirely
   always_comb begin
      state_n    = state;
      con_stb_n  = o_con_stb;
      con_data_n = o_con_data;
      pop        = 1'b0;
      unique case (state)
         DRN_IDLE: begin
            if (!empty) begin
               state_n    = DRN_REQ;
               con_stb_n  = 1'b1;
               con_data_n = {24'h0, head};
            end
         end
         DRN_REQ: begin
            if (!i_con_stall) begin
               con_stb_n = 1'b0;
               if (i_con_ack) begin
                  pop     = 1'b1;
                  state_n = DRN_IDLE;
               end else begin
                  state_n = DRN_WAIT;
               end
            end
         end
         DRN_WAIT: begin
            if (i_con_ack) begin
               pop     = 1'b1;
               state_n = DRN_IDLE;
            end
         end
         default: begin
            state_n = DRN_IDLE;
         end
      endcase
   end

endmodule
